// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 4-bit ALU among NUM_REQ requesters, with an in-order
// tag FIFO that routes each result back to its issuer. Optional macro: ALU_ARB_PRIO0_EN (requester 0 strict priority).
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]     req_cin,
  input  logic [4*NUM_REQ-1:0]   req_ctl,
  output logic                   alu_valid_in,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [3:0]             alu_ctl,
  input  logic                   alu_valid_out,
  input  logic [3:0]             alu_res,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [3:0]             rsp_res,
  output logic                   rsp_carry,
  output logic                   rsp_zero,
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [TAG_W-1:0] rr_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] tag_mem [MAX_OUT];
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_found;
  logic             full;
  logic             push;
  logic             pop;
  logic             orphan;

  assign full   = (count == CNT_W'(MAX_OUT));
  assign push   = gnt_found;
  assign pop    = alu_valid_out & (count != '0);
  assign orphan = alu_valid_out & (count == '0);
  assign busy   = (count != '0);

  // Grant: first valid requester at or above rr_ptr, wrapping; nothing while the tag FIFO is full.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (!full) begin
`ifdef ALU_ARB_PRIO0_EN
      if (req_valid[0]) begin
        gnt_found = 1'b1;
        gnt_idx   = '0;
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!gnt_found && req_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = TAG_W'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (push) begin
`ifdef ALU_ARB_PRIO0_EN
      if (gnt_idx != '0)
        rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`else
      rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
    end
  end

  // Issue stage: operands of the granted requester drive the ALU one cycle after the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_valid_in <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cin      <= 1'b0;
      alu_ctl      <= '0;
    end else begin
      alu_valid_in <= push;
      if (push) begin
        alu_a   <= req_a[4*gnt_idx +: 4];
        alu_b   <= req_b[4*gnt_idx +: 4];
        alu_cin <= req_cin[gnt_idx];
        alu_ctl <= req_ctl[4*gnt_idx +: 4];
      end
    end
  end

  // Tag FIFO: requester IDs in issue order, matched to in-order ALU results.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      err_orphan <= 1'b0;
    else if (orphan) err_orphan <= 1'b1;
  end

  // Response path: combinational from the ALU, strobing the requester at the FIFO head.
  always_comb begin
    rsp_valid = '0;
    if (pop) rsp_valid[tag_mem[rd_ptr]] = 1'b1;
  end

  assign rsp_res   = alu_res;
  assign rsp_carry = alu_carry;
  assign rsp_zero  = alu_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;
  localparam int N = 4;
  localparam int M = 4;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0] req_a = '0, req_b = '0, req_ctl = '0;
  logic [N-1:0]  req_cin = '0;
  logic          alu_valid_in, alu_cin;
  logic [3:0]    alu_a, alu_b, alu_ctl;
  logic          alu_valid_out, alu_carry, alu_zero;
  logic [3:0]    alu_res;
  logic [N-1:0]  rsp_valid;
  logic [3:0]    rsp_res;
  logic          rsp_carry, rsp_zero, busy, err_orphan;

  int vectors = 0;
  int miscompares = 0;

  alu_arbiter #(.NUM_REQ(N), .MAX_OUT(M)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ctl(req_ctl),
    .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctl(alu_ctl),
    .alu_valid_out(alu_valid_out), .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // Reference ALU result as {zero, carry, res}; op packs {ctl, cin, b, a}.
  function automatic logic [5:0] alu_fn(input logic [12:0] op);
    logic [4:0] s;
    logic [3:0] a, b, ctl;
    a = op[3:0]; b = op[7:4]; ctl = op[12:9];
    case (ctl)
      OP_ADD:  s = {1'b0, a} + {1'b0, b} + {4'b0, op[8]};
      OP_XOR:  s = {1'b0, a ^ b};
      default: s = {1'b0, a & b};
    endcase
    return {(s[3:0] == 4'h0), s[4], s[3:0]};
  endfunction

  // Bench ALU, latency 1, sharing the arbiter reset; or manual drive for corner cases.
  logic       alu_auto = 1'b1;
  logic       man_vo = 1'b0;
  logic [3:0] man_res = 4'hA;
  logic       aluq_v;
  logic [5:0] aluq_r;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      aluq_v <= 1'b0;
      aluq_r <= '0;
    end else begin
      aluq_v <= alu_valid_in;
      aluq_r <= alu_fn({alu_ctl, alu_cin, alu_b, alu_a});
    end
  end
  assign alu_valid_out = alu_auto ? aluq_v    : man_vo;
  assign alu_res       = alu_auto ? aluq_r[3:0] : man_res;
  assign alu_carry     = alu_auto ? aluq_r[4] : 1'b1;
  assign alu_zero      = alu_auto ? aluq_r[5] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Model: pointer, queue of in-flight requester IDs and their ops, issue register image.
  int         m_ptr = 0;
  int         m_tags[$];
  logic [12:0] m_ops[$];
  logic       m_vin = 1'b0;
  logic [3:0] m_a = '0, m_b = '0, m_ctl = '0;
  logic       m_cin = 1'b0;
  logic       m_orphan = 1'b0;

  function automatic int exp_grant();
    if (m_tags.size() >= M) return -1;
`ifdef ALU_ARB_PRIO0_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    int g;
    if (!reset) begin
      m_ptr = 0; m_tags.delete(); m_ops.delete();
      m_vin = 1'b0; m_a = '0; m_b = '0; m_ctl = '0; m_cin = 1'b0; m_orphan = 1'b0;
    end else begin
      g = exp_grant();
      if (alu_valid_out) begin
        if (m_tags.size() == 0) m_orphan = 1'b1;
        else begin
          void'(m_tags.pop_front());
          void'(m_ops.pop_front());
        end
      end
      m_vin = (g >= 0);
      if (g >= 0) begin
        m_a = req_a[4*g +: 4]; m_b = req_b[4*g +: 4];
        m_cin = req_cin[g];    m_ctl = req_ctl[4*g +: 4];
        m_tags.push_back(g);
        m_ops.push_back({m_ctl, m_cin, m_b, m_a});
`ifdef ALU_ARB_PRIO0_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [31:0] er;
    logic [5:0] r;
    g = exp_grant();
    chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    er = (alu_valid_out && m_tags.size() != 0) ? 32'(1 << m_tags[0]) : 32'd0;
    chk("rsp_valid", 32'(rsp_valid), er);
    if (er != 0) begin
      if (alu_auto) begin
        r = alu_fn(m_ops[0]);
        chk("rsp_result", {26'd0, rsp_zero, rsp_carry, rsp_res}, {26'd0, r});
      end else begin
        chk("rsp_passthru", {26'd0, rsp_zero, rsp_carry, rsp_res}, {26'd0, alu_zero, alu_carry, alu_res});
      end
    end
    chk("alu_valid_in", 32'(alu_valid_in), 32'(m_vin));
    chk("alu_operands", {19'd0, alu_ctl, alu_cin, alu_b, alu_a}, {19'd0, m_ctl, m_cin, m_b, m_a});
    chk("busy", 32'(busy), 32'(m_tags.size() != 0));
    chk("err_orphan", 32'(err_orphan), 32'(m_orphan));
  end

  task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [3:0] ctl);
    bit got;
    got = 1'b0;
    req_a[4*i +: 4] = a; req_b[4*i +: 4] = b; req_cin[i] = cin; req_ctl[4*i +: 4] = ctl;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    if (!got) timeout("issue");
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [N-1:0] v, output logic [3:0] r, output logic c, output logic z);
    bit got;
    got = 1'b0; v = '0; r = '0; c = 1'b0; z = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = 1'b1; v = rsp_valid; r = rsp_res; c = rsp_carry; z = rsp_zero;
      end
    end
    if (!got) timeout("wait_rsp");
  endtask

  task automatic drain_auto();
    for (int c = 0; c < 30 && busy; c++) begin
      @(posedge clk); #1;
    end
    if (busy) timeout("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] v;
    logic [3:0]   r;
    logic         c, z;
    #1 reset = 1'b0;
    req_valid = 4'b0110;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h2);
    chk("rst_valid_in", 32'(alu_valid_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Fairness: all four requesters held valid.
    req_a = 16'h8765; req_b = 16'h3210; req_cin = 4'b1010; req_ctl = {4'h2, OP_XOR, OP_ADD, OP_ADD};
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef ALU_ARB_PRIO0_EN
      chk("fair_grant", 32'(req_ready), 32'h1);
`else
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
`endif
    end
    @(posedge clk); #1 req_valid = '0;
    drain_auto();

    // Routing: req2 ADD 9+8 -> 1 with carry; req1 XOR 5^5 -> 0 with zero.
    issue(2, 4'h9, 4'h8, 1'b0, OP_ADD);
    wait_rsp(v, r, c, z);
    chk("route_valid", 32'(v), 32'h4);
    chk("route_res", 32'(r), 32'h1);
    chk("route_flags", {30'd0, c, z}, 32'h2);
    issue(1, 4'h5, 4'h5, 1'b1, OP_XOR);
    wait_rsp(v, r, c, z);
    chk("xor_valid", 32'(v), 32'h2);
    chk("xor_res", {27'd0, z, r}, 32'h10);
    drain_auto();

    // Full: no results returned, four accepts fill the FIFO.
    alu_auto = 1'b0; man_vo = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fill_ready", 32'(|req_ready), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 man_vo = 1'b1;
    @(negedge clk);
    chk("pop_same_cycle", 32'(req_ready), 32'd0);
    chk("pop_rsp", 32'(|rsp_valid), 32'd1);
    @(posedge clk); #1 man_vo = 1'b0;
    @(negedge clk);
    chk("freed_ready", 32'(|req_ready), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 20 && busy; k++) begin
      man_vo = 1'b1;
      @(posedge clk); #1;
    end
    man_vo = 1'b0;
    if (busy) timeout("drain_manual");

    // Reset mid-stream with three operations in flight.
    req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    req_valid = 4'b1111;
    reset = 1'b0;
    #1;
    chk("midrst_valid_in", 32'(alu_valid_in), 32'd0);
    chk("midrst_operands", {19'd0, alu_ctl, alu_cin, alu_b, alu_a}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b1;

    // Orphan result with an empty FIFO.
    @(posedge clk); #1 man_vo = 1'b1;
    @(negedge clk);
    chk("orphan_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 man_vo = 1'b0;
    chk("orphan_set", 32'(err_orphan), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("orphan_sticky", 32'(err_orphan), 32'd1);
    alu_auto = 1'b1;

`ifdef ALU_ARB_PRIO0_EN
    req_valid = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("prio0_grant", 32'(req_ready), 32'h1);
    end
    @(posedge clk); #1 req_valid = 4'b0010;
    @(negedge clk);
    chk("prio0_drop", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = '0;
    drain_auto();
`endif

    reset = 1'b0;
    #1 chk("final_rst_orphan", 32'(err_orphan), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
